// File: rtl/cim_system_io_ctrl_if.sv
// -----------------------------------------------------------------------------
// cim_system_io_ctrl_if
// Bundles the pad-side command/result signals and the CIM macro strobe/result
// signals of the chip-level IO controller.
//   modport slave  : the controller (takes pad commands and macro results,
//                    drives pad results and macro strobes)
//   modport master : the environment (pads + macro), opposite directions
// Parameters must match those of the controller instance using it.
// -----------------------------------------------------------------------------
interface cim_system_io_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9,
  parameter int OUT_W  = 6,
  parameter int NUM_CH = 4,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  // pad side
  logic                     wen;
  logic                     wbuf;
  logic                     cal;
  logic [ADDR_W-1:0]        a_chip;
  logic [DATA_W-1:0]        d;
  logic                     eact;
  logic                     busy;
  logic [OUT_W-1:0]         q;
  logic [CH_W-1:0]          q_ch;
  logic                     q_valid;
  logic                     cal_done;
  logic                     err;
  // macro side
  logic [ADDR_W-1:0]        cim_a;
  logic [DATA_W-1:0]        cim_d;
  logic                     cim_wrt;
  logic                     cim_wrtbuf;
  logic                     cim_read;
  logic                     cim_done;
  logic [NUM_CH*OUT_W-1:0]  cim_q;

  modport slave (
    input  wen, wbuf, cal, a_chip, d, eact, cim_done, cim_q,
    output busy, q, q_ch, q_valid, cal_done, err,
           cim_a, cim_d, cim_wrt, cim_wrtbuf, cim_read
  );

  modport master (
    output wen, wbuf, cal, a_chip, d, eact, cim_done, cim_q,
    input  busy, q, q_ch, q_valid, cal_done, err,
           cim_a, cim_d, cim_wrt, cim_wrtbuf, cim_read
  );
endinterface

// File: rtl/cim_system_io_ctrl.sv
// -----------------------------------------------------------------------------
// cim_system_io_ctrl
// Chip-level IO controller between the pad interface and the CIM macro.
// Pad commands (write, write-buffer, calculate) are accepted in IDLE and turned
// into single-cycle macro strobes. A calculate issues a macro read, waits for
// cim_done, captures NUM_CH result channels (optionally through ReLU) and
// drains them to the pads one channel per cycle, followed by a cal_done pulse.
//
// Ports
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : cim_system_io_ctrl_if.slave (pad commands/results and macro
//                strobes/results, see the interface file)
//
// Optional feature macro: CIM_IO_TIMEOUT_EN
//   defined   : CAL_WAIT watchdog of TMO_CYC cycles; on expiry err is set
//               (sticky until reset), cal_done pulses without any q_valid.
//   undefined : CAL_WAIT waits indefinitely, err is tied low.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | waiting for a pad command (priority wen > wbuf > cal)
// S_WR       | cim_wrt strobe, one cycle
// S_WB       | cim_wrtbuf strobe, one cycle
// S_CAL_RD   | cim_read strobe, one cycle
// S_CAL_WAIT | waiting for cim_done (or watchdog expiry)
// S_DRAIN    | q_valid high, one channel per cycle, q_ch 0..NUM_CH-1
// S_DONE     | cal_done pulse, one cycle
// -----------------------------------------------------------------------------
module cim_system_io_ctrl #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 9,
  parameter int OUT_W   = 6,
  parameter int NUM_CH  = 4,
  parameter int TMO_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cim_system_io_ctrl_if.slave  bus
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR       = 3'd1;
  localparam logic [2:0] S_WB       = 3'd2;
  localparam logic [2:0] S_CAL_RD   = 3'd3;
  localparam logic [2:0] S_CAL_WAIT = 3'd4;
  localparam logic [2:0] S_DRAIN    = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  logic [2:0]                         r_state;
  logic [2:0]                         w_state_nxt;
  logic [ADDR_W-1:0]                  r_cim_a;
  logic [DATA_W-1:0]                  r_cim_d;
  logic                               r_eact;
  logic [NUM_CH-1:0][OUT_W-1:0]       r_res;
  logic [OUT_W-1:0]                   r_q;
  logic [CH_W-1:0]                    r_q_ch;
  logic [CH_W-1:0]                    w_ch_nxt;
  logic [NUM_CH-1:0][OUT_W-1:0]       w_act;
  logic [OUT_W-1:0]                   w_ch;
  logic                               w_capture;

`ifdef CIM_IO_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0]                   r_tmo;
  logic                               r_err;
`endif

  // Macro results with the activation latched at command accept applied.
  always_comb begin
    w_act = '0;
    w_ch  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_ch = bus.cim_q[i*OUT_W +: OUT_W];
      w_act[i] = (r_eact && w_ch[OUT_W-1]) ? '0 : w_ch;
    end
  end

  assign w_capture = (r_state == S_CAL_WAIT) && bus.cim_done;
  assign w_ch_nxt  = r_q_ch + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.wen)       w_state_nxt = S_WR;
        else if (bus.wbuf) w_state_nxt = S_WB;
        else if (bus.cal)  w_state_nxt = S_CAL_RD;
      end
      S_WR, S_WB: w_state_nxt = S_IDLE;
      S_CAL_RD:   w_state_nxt = S_CAL_WAIT;
      S_CAL_WAIT: begin
        if (bus.cim_done) w_state_nxt = S_DRAIN;
`ifdef CIM_IO_TIMEOUT_EN
        // cim_done wins over expiry when both land in the same cycle.
        else if (r_tmo == '0) w_state_nxt = S_DONE;
`endif
      end
      S_DRAIN: begin
        if (r_q_ch == LAST_CH) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Macro address/data are loaded on accept so they are already stable in the
  // strobe cycle and simply hold afterwards. A calculate leaves cim_d alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cim_a <= '0;
      r_cim_d <= '0;
      r_eact  <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (bus.wen || bus.wbuf) begin
        r_cim_a <= bus.a_chip;
        r_cim_d <= bus.d;
      end else if (bus.cal) begin
        r_cim_a <= bus.a_chip;
        r_eact  <= bus.eact;
      end
    end
  end

  // Channel 0 goes straight to q on capture so that q/q_ch are valid in the
  // first DRAIN cycle; q then steps through the buffer and holds the last
  // channel once the drain is over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res  <= '0;
      r_q    <= '0;
      r_q_ch <= '0;
    end else if (w_capture) begin
      r_res  <= w_act;
      r_q    <= w_act[0];
      r_q_ch <= '0;
    end else if ((r_state == S_DRAIN) && (r_q_ch != LAST_CH)) begin
      r_q    <= r_res[w_ch_nxt];
      r_q_ch <= w_ch_nxt;
    end
  end

`ifdef CIM_IO_TIMEOUT_EN
  // Down-counter loaded in CAL_RD; reaching zero in the TMO_CYC-th CAL_WAIT
  // cycle without cim_done is the expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == S_CAL_RD)
        r_tmo <= TMO_W'(TMO_CYC - 1);
      else if ((r_state == S_CAL_WAIT) && (r_tmo != '0))
        r_tmo <= r_tmo - 1'b1;
      if ((r_state == S_CAL_WAIT) && !bus.cim_done && (r_tmo == '0))
        r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.busy       = (r_state != S_IDLE);
  assign bus.cim_wrt    = (r_state == S_WR);
  assign bus.cim_wrtbuf = (r_state == S_WB);
  assign bus.cim_read   = (r_state == S_CAL_RD);
  assign bus.q_valid    = (r_state == S_DRAIN);
  assign bus.cal_done   = (r_state == S_DONE);
  assign bus.cim_a      = r_cim_a;
  assign bus.cim_d      = r_cim_d;
  assign bus.q          = r_q;
  assign bus.q_ch       = r_q_ch;

endmodule

// File: tb/tb_cim_system_io_ctrl.sv
`timescale 1ns/1ps
module tb_cim_system_io_ctrl;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 9;
  localparam int OUT_W   = 6;
  localparam int NUM_CH  = 4;
  localparam int TMO_CYC = 64;
  localparam int QW      = NUM_CH * OUT_W;
  localparam int K_W = 0, K_B = 1, K_R = 2;
  localparam int TBL_DLY = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cim_system_io_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OUT_W(OUT_W),
                          .NUM_CH(NUM_CH)) bus ();

  cim_system_io_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OUT_W(OUT_W),
                       .NUM_CH(NUM_CH), .TMO_CYC(TMO_CYC))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef struct {
    int                           n_wrt, n_wb, n_rd, nb, ndone, strobe_k, lat;
    logic [ADDR_W-1:0]            a;
    logic [DATA_W-1:0]            d;
    logic [NUM_CH-1:0][OUT_W-1:0] beats;
    bit                           ch_ok;
    logic                         err;
    logic [OUT_W-1:0]             q_after;
  } obs_t;

  typedef struct {
    logic              w, wb, c;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              e;
    logic [QW-1:0]     cq;
    bit                noise;
    int                e_kind;
    logic [ADDR_W-1:0] e_a;
    logic [DATA_W-1:0] e_d;
    logic [QW-1:0]     e_q;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // reference-model state
  logic [DATA_W-1:0] m_last_d;
  logic [OUT_W-1:0]  m_last_q;
  logic              m_err;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic obs_t obs_init();
    obs_t o;
    o.n_wrt = 0; o.n_wb = 0; o.n_rd = 0; o.nb = 0; o.ndone = 0;
    o.strobe_k = -1; o.lat = 0; o.a = '0; o.d = '0; o.beats = '0;
    o.ch_ok = 1'b1; o.err = 1'b0; o.q_after = '0;
    return o;
  endfunction

  function automatic logic [39:0] all_outs();
    return {bus.busy, bus.q, bus.q_ch, bus.q_valid, bus.cal_done, bus.err,
            bus.cim_a, bus.cim_d, bus.cim_wrt, bus.cim_wrtbuf, bus.cim_read};
  endfunction

  task automatic clear_drives();
    bus.wen = 0; bus.wbuf = 0; bus.cal = 0; bus.cim_done = 0;
  endtask

  task automatic reset_all();
    clear_drives();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    m_last_d = '0; m_last_q = '0; m_err = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (!bus.busy) return;
      @(negedge clk);
    end
    check("wait_idle_busy", {63'd0, bus.busy}, 64'd0);
  endtask

  // Issues one pad command and observes everything until the controller is back
  // in IDLE. dly > 0: cim_done is returned dly cycles after cim_read; dly = 0:
  // cim_done is never returned. noise: commands while busy, spurious cim_done
  // during the drain.
  task automatic do_txn(input logic w, input logic wb, input logic c,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic e, input logic [QW-1:0] cq, input int dly,
                        input bit noise, output obs_t o);
    int rd_k, done_k;
    bit finished;
    o = obs_init();
    rd_k = -1; done_k = -1; finished = 0;
    wait_idle();
    bus.wen = w; bus.wbuf = wb; bus.cal = c; bus.a_chip = a; bus.d = d; bus.eact = e;
    @(negedge clk);
    for (int k = 0; k < TMO_CYC + 40 + dly; k++) begin
      clear_drives();
      if (bus.cim_wrt)    begin o.n_wrt++; o.a = bus.cim_a; o.d = bus.cim_d; o.strobe_k = k; end
      if (bus.cim_wrtbuf) begin o.n_wb++;  o.a = bus.cim_a; o.d = bus.cim_d; o.strobe_k = k; end
      if (bus.cim_read)   begin o.n_rd++;  o.a = bus.cim_a; o.d = bus.cim_d; o.strobe_k = k; rd_k = k; end
      if (bus.q_valid) begin
        if (o.nb < NUM_CH) o.beats[o.nb] = bus.q;
        if (int'(bus.q_ch) != o.nb) o.ch_ok = 1'b0;
        o.nb++;
      end
      if (bus.cal_done) begin o.ndone++; done_k = k; end
      o.err = bus.err;
      if (!bus.busy) begin finished = 1; break; end
      if (rd_k >= 0 && dly > 0 && k == rd_k + dly) begin
        bus.cim_done = 1; bus.cim_q = cq;
      end else if (noise && bus.q_valid) begin
        bus.cim_done = 1; bus.cim_q = ~cq;
      end
      if (noise) begin
        bus.wen = 1'($urandom_range(0, 1)); bus.wbuf = 1'($urandom_range(0, 1));
        bus.cal = 1; bus.a_chip = ADDR_W'($urandom); bus.d = DATA_W'($urandom);
      end
      @(negedge clk);
    end
    clear_drives();
    if (!finished) check("txn_not_idle", {63'd0, bus.busy}, 64'd0);
    o.q_after = bus.q;
    if (rd_k >= 0 && done_k >= 0) o.lat = done_k - rd_k;
  endtask

  // Transaction-level reference: what the pads and macro should see.
  task automatic model_step(input logic w, input logic wb, input logic c,
                            input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input logic e, input logic [QW-1:0] cq, input int dly,
                            output obs_t x);
    logic [OUT_W-1:0] v;
    x = obs_init();
    x.strobe_k = 0;
    x.a = a;
    if (w) begin
      x.n_wrt = 1; x.d = d; m_last_d = d;
    end else if (wb) begin
      x.n_wb = 1; x.d = d; m_last_d = d;
    end else if (c) begin
      x.n_rd = 1; x.d = m_last_d; x.ndone = 1;
      if (dly > 0) begin
        x.nb = NUM_CH;
        for (int ch = 0; ch < NUM_CH; ch++) begin
          v = cq[ch*OUT_W +: OUT_W];
          x.beats[ch] = (e && $signed(v) < 0) ? '0 : v;
        end
        x.lat = dly + NUM_CH + 1;
        m_last_q = x.beats[NUM_CH-1];
      end else begin
        x.lat = TMO_CYC + 1;
        m_err = 1'b1;
      end
    end
    x.err = m_err;
    x.q_after = m_last_q;
  endtask

  task automatic compare(input string tag, input obs_t o, input obs_t x);
    check({tag, ".n_wrt"},    o.n_wrt, x.n_wrt);
    check({tag, ".n_wrtbuf"}, o.n_wb, x.n_wb);
    check({tag, ".n_read"},   o.n_rd, x.n_rd);
    check({tag, ".strobe_k"}, o.strobe_k, x.strobe_k);
    check({tag, ".cim_a"},    o.a, x.a);
    check({tag, ".cim_d"},    o.d, x.d);
    check({tag, ".n_beats"},  o.nb, x.nb);
    check({tag, ".beats"},    o.beats, x.beats);
    check({tag, ".q_ch_seq"}, {63'd0, o.ch_ok}, 64'd1);
    check({tag, ".cal_done"}, o.ndone, x.ndone);
    check({tag, ".err"},      o.err, x.err);
    check({tag, ".q_hold"},   o.q_after, x.q_after);
    if (x.n_rd == 1) check({tag, ".latency"}, o.lat, x.lat);
  endtask

  vec_t tbl[7];
  obs_t o, x;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [OUT_W-1:0] t_last_q;
    logic [2:0] r3;
    int dly;
    bit nz, hit;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic re;
    logic [QW-1:0] rq;

    //            w  wb c  a       d         e  cq                                 nz kind e_a     e_d       e_q
    tbl[0] = '{1, 0, 0, 9'h0A5, 16'hBEEF, 0, '0,                                 0, K_W, 9'h0A5, 16'hBEEF, '0};
    tbl[1] = '{0, 1, 0, 9'h1FF, 16'h1234, 0, '0,                                 0, K_B, 9'h1FF, 16'h1234, '0};
    tbl[2] = '{1, 1, 1, 9'h033, 16'h5555, 1, '0,                                 0, K_W, 9'h033, 16'h5555, '0};
    tbl[3] = '{0, 0, 1, 9'h010, 16'hFFFF, 0, {6'h1F, 6'h20, 6'h05, 6'h3F},       1, K_R, 9'h010, 16'h5555, {6'h1F, 6'h20, 6'h05, 6'h3F}};
    tbl[4] = '{0, 0, 1, 9'h011, 16'hFFFF, 1, {6'h1F, 6'h20, 6'h05, 6'h3F},       1, K_R, 9'h011, 16'h5555, {6'h1F, 6'h00, 6'h05, 6'h00}};
    tbl[5] = '{0, 1, 1, 9'h100, 16'h0F0F, 1, '0,                                 0, K_B, 9'h100, 16'h0F0F, '0};
    tbl[6] = '{0, 0, 1, 9'h000, 16'h0000, 1, {6'h21, 6'h01, 6'h1F, 6'h20},       0, K_R, 9'h000, 16'h0F0F, {6'h00, 6'h01, 6'h1F, 6'h00}};

    clear_drives();
    bus.a_chip = '0; bus.d = '0; bus.eact = 0; bus.cim_q = '0;
    rst_n = 0;
    #1;
    check("reset_outputs", all_outs(), 40'd0);
    reset_all();

    // directed table
    t_last_q = '0;
    for (int i = 0; i < 7; i++) begin
      do_txn(tbl[i].w, tbl[i].wb, tbl[i].c, tbl[i].a, tbl[i].d, tbl[i].e,
             tbl[i].cq, TBL_DLY, tbl[i].noise, o);
      x = obs_init();
      x.strobe_k = 0;
      x.n_wrt = (tbl[i].e_kind == K_W) ? 1 : 0;
      x.n_wb  = (tbl[i].e_kind == K_B) ? 1 : 0;
      x.n_rd  = (tbl[i].e_kind == K_R) ? 1 : 0;
      x.a = tbl[i].e_a;
      x.d = tbl[i].e_d;
      if (tbl[i].e_kind == K_R) begin
        x.nb = NUM_CH; x.ndone = 1; x.beats = tbl[i].e_q;
        x.lat = TBL_DLY + NUM_CH + 1;
        t_last_q = tbl[i].e_q[QW-1 -: OUT_W];
      end
      x.q_after = t_last_q;
      compare($sformatf("tbl%0d", i), o, x);
    end

    // reset in the middle of the drain, right after channel 1
    reset_all();
    wait_idle();
    bus.cal = 1; bus.a_chip = 9'h055; bus.eact = 0;
    @(negedge clk);
    bus.cal = 0;
    hit = 0;
    for (int k = 0; k < 20 && !hit; k++) begin
      if (bus.cim_read) hit = 1;
      @(negedge clk);
    end
    check("mid_rst_read_seen", {63'd0, hit}, 64'd1);
    bus.cim_done = 1; bus.cim_q = {6'h11, 6'h12, 6'h13, 6'h14};
    @(negedge clk);
    bus.cim_done = 0;
    hit = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.q_valid && bus.q_ch == 2'd1) begin hit = 1; break; end
      @(negedge clk);
    end
    check("mid_rst_ch1_seen", {63'd0, hit}, 64'd1);
    check("mid_rst_ch1_q", bus.q, 6'h13);
    rst_n = 0;
    #1;
    check("mid_rst_outputs", all_outs(), 40'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("after_rst_outputs", all_outs(), 40'd0);
    m_last_d = '0; m_last_q = '0; m_err = 1'b0;
    model_step(0, 0, 1, 9'h056, 16'h0, 1, {6'h30, 6'h0F, 6'h3E, 6'h02}, 2, x);
    do_txn(0, 0, 1, 9'h056, 16'h0, 1, {6'h30, 6'h0F, 6'h3E, 6'h02}, 2, 0, o);
    compare("post_rst_cal", o, x);

    // randomized transactions against the reference model
    for (int i = 0; i < 40; i++) begin
      r3  = 3'($urandom_range(1, 7));
      ra  = ADDR_W'($urandom);
      rd  = DATA_W'($urandom);
      re  = 1'($urandom_range(0, 1));
      rq  = QW'($urandom);
      dly = $urandom_range(1, 8);
      nz  = 1'($urandom_range(0, 1));
      model_step(r3[2], r3[1], r3[0], ra, rd, re, rq, dly, x);
      do_txn(r3[2], r3[1], r3[0], ra, rd, re, rq, dly, nz, o);
      compare($sformatf("rnd%0d", i), o, x);
    end

`ifdef CIM_IO_TIMEOUT_EN
    model_step(0, 0, 1, 9'h0C0, 16'h0, 0, '0, 0, x);
    do_txn(0, 0, 1, 9'h0C0, 16'h0, 0, '0, 0, 0, o);
    compare("timeout", o, x);
    model_step(0, 0, 1, 9'h0C1, 16'h0, 0, {6'h01, 6'h02, 6'h03, 6'h04}, 4, x);
    do_txn(0, 0, 1, 9'h0C1, 16'h0, 0, {6'h01, 6'h02, 6'h03, 6'h04}, 4, 0, o);
    compare("err_sticky", o, x);
    reset_all();
    check("err_cleared", {63'd0, bus.err}, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
